ahb_master_req_ctrl: RTL and testbench
======================================

AHB_MASTER_REQ_CTRL -- requirements
Module: ahb_master_req_ctrl

Interface
REQ-001 Parameter PRIOR_BIT, default 1: width of the priority field driven to the slave-side arbiter.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: number of ungranted request cycles before abort; only used when REQ_TIMEOUT_EN is defined.
REQ-003 Port hclk  input  1: clock; all state SHALL update on its rising edge.
REQ-004 Port hreset_n  input  1: reset, asynchronous, active-low.
REQ-005 Port cmd_valid  input  1: the master core requests a transaction.
REQ-006 Port cmd_burst  input  hburst_type (3): burst type of the requested transaction.
REQ-007 Port cmd_len  input  4: beat count minus 1 for an INCR burst; ignored for all other burst types.
REQ-008 Port cmd_prior  input  PRIOR_BIT: transaction priority.
REQ-009 Port cmd_ready  output  1: the block accepts a command.
REQ-010 Port hreq  output  1: request to the arbiter.
REQ-011 Port hprior  output  PRIOR_BIT: priority presented to the arbiter.
REQ-012 Port hburst  output  hburst_type: burst type presented to the arbiter.
REQ-013 Port hgrant  input  1: a beat is accepted this cycle (granted and slave not waiting).
REQ-014 Port hwait  input  1: the slave is stalling the current beat.
REQ-015 Port beat_cnt  output  4: index of the next beat to be accepted.
REQ-016 Port beat_last  output  1: the next accepted beat is the final beat.
REQ-017 Port done  output  1: one-cycle pulse when the final beat is accepted.
REQ-018 Port timeout_err  output  1: one-cycle abort pulse; present only when REQ_TIMEOUT_EN is defined.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQUEST and BURST.
REQ-020 IDLE behaviour:
- cmd_ready=1 and hreq=0.
- On cmd_valid, latch cmd_burst, cmd_prior and the beat limit, clear beat_cnt, and go to REQUEST.
- hreq SHALL rise in the following cycle.
REQ-021 The beat limit SHALL be:
- SINGLE=0
- INCR=cmd_len
- WRAP4/INCR4=3
- WRAP8/INCR8=7
- WRAP16/INCR16=15
REQ-022 REQUEST behaviour:
- hreq=1, hprior and hburst driven from the latched values, cmd_ready=0.
- On hgrant with limit 0, pulse done and go to IDLE.
- On hgrant with limit >0, increment beat_cnt and go to BURST.
REQ-023 BURST behaviour:
- hreq held at 1.
- Each cycle with hgrant=1 increments beat_cnt.
- hgrant while beat_cnt==limit pulses done, clears beat_cnt and returns to IDLE.
REQ-024 A cycle with hgrant=0 (due to hwait or a withdrawn grant) SHALL hold beat_cnt and the state; hreq stays asserted.
REQ-025 hreq, hprior and hburst SHALL be registered outputs, and hreq SHALL be 0 in the cycle after done.
REQ-026 beat_last SHALL equal (state!=IDLE) && (beat_cnt==limit), decoded combinationally.
REQ-027 cmd_valid while cmd_ready=0 SHALL be ignored; the core holds it until accepted.
REQ-028 A back-to-back command SHALL be accepted no earlier than the cycle after done, giving a minimum of one hreq-low cycle between transactions.
REQ-029 beat_cnt SHALL saturate at 15 and never wrap within a transaction.

Reset
REQ-030 While hreset_n=0:
- state=IDLE, hreq=0, hprior=0, hburst=SINGLE, beat_cnt=0, done=0, timeout_err=0.
- cmd_ready=1.
REQ-031 Reset asserted mid-burst SHALL abort the transaction immediately with no done pulse; the latched command is discarded.

Configuration
REQ-032 Macro AHB_MASTER_REQ_TIMEOUT_EN, when defined:
- A counter runs while in REQUEST.
- After TIMEOUT_CYCLES consecutive cycles without hgrant, the block pulses timeout_err, drops hreq and returns to IDLE without done.
- The counter clears on hgrant and on entry to REQUEST; BURST is never timed out.
REQ-033 When AHB_MASTER_REQ_TIMEOUT_EN is undefined, the counter and the timeout_err port SHALL be absent, and REQUEST waits for hgrant indefinitely.

Verification
REQ-034 SINGLE, prior=1, hgrant one cycle after hreq rises -> done one cycle later; hreq low the next cycle; beat_cnt=0.
REQ-035 INCR4 with hgrant continuous -> 4 grant cycles; beat_last in the 4th; done exactly once; hreq deasserts after beat 3.
REQ-036 INCR8 with hwait=1 (hgrant=0) for 3 cycles after beat 2 -> beat_cnt holds at 3 through the stall; done after 8 total grants.
REQ-037 INCR with cmd_len=5 -> 6 beats; then a second command presented immediately -> at least one hreq=0 cycle between the two transactions.
REQ-038 WRAP16 with hreset_n asserted at beat 9 -> all outputs return to their reset values asynchronously; no done pulse.
REQ-039 With AHB_MASTER_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, hgrant never asserted -> timeout_err pulses in the 64th REQUEST cycle; hreq=0 the next cycle; no done pulse.

Source files
------------

// File: rtl/ahb_master_req_ctrl.sv
// ahb_master_req_ctrl: AHB master-side request controller.
// Accepts one command at a time from the master core, raises a registered
// request to the arbiter and counts accepted beats until the burst completes.
// Optional feature macro: AHB_MASTER_REQ_TIMEOUT_EN (abort an ungranted
// request after TIMEOUT_CYCLES cycles and pulse timeout_err).
module ahb_master_req_ctrl #(
  parameter  int unsigned PRIOR_BIT      = 1,
  parameter  int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned BURST_W        = 3,
  localparam int unsigned CNT_W          = 4
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic                 cmd_valid,
  input  logic [BURST_W-1:0]   cmd_burst,
  input  logic [CNT_W-1:0]     cmd_len,
  input  logic [PRIOR_BIT-1:0] cmd_prior,
  output logic                 cmd_ready,
  output logic                 hreq,
  output logic [PRIOR_BIT-1:0] hprior,
  output logic [BURST_W-1:0]   hburst,
  input  logic                 hgrant,
  input  logic                 hwait,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic                 beat_last,
  output logic                 done
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  // AHB HBURST encodings
  localparam logic [BURST_W-1:0] HB_SINGLE = 3'd0;
  localparam logic [BURST_W-1:0] HB_INCR   = 3'd1;
  localparam logic [BURST_W-1:0] HB_WRAP4  = 3'd2;
  localparam logic [BURST_W-1:0] HB_INCR4  = 3'd3;
  localparam logic [BURST_W-1:0] HB_WRAP8  = 3'd4;
  localparam logic [BURST_W-1:0] HB_INCR8  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(15);

`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_BURST   = 2'd2
  } state_t;

  state_t                 state_q, state_nxt;
  logic [CNT_W-1:0]       limit_q, limit_nxt;
  logic [CNT_W-1:0]       beat_cnt_nxt;
  logic [PRIOR_BIT-1:0]   hprior_nxt;
  logic [BURST_W-1:0]     hburst_nxt;
  logic                   hreq_nxt;
  logic                   done_nxt;
  logic                   cmd_ready_nxt;
  logic                   abort_c;
  logic                   beat_acc_c;
  logic [CNT_W-1:0]       cnt_inc_c;

`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  logic [TO_W-1:0]        to_cnt_q, to_cnt_nxt;
`endif

  // Last beat index (beats minus one) for a given burst type
  function automatic logic [CNT_W-1:0] burst_limit(input logic [BURST_W-1:0] burst,
                                                   input logic [CNT_W-1:0]   len);
    logic [CNT_W-1:0] lim;
    case (burst)
      HB_SINGLE:          lim = CNT_W'(0);
      HB_INCR:            lim = len;
      HB_WRAP4, HB_INCR4: lim = CNT_W'(3);
      HB_WRAP8, HB_INCR8: lim = CNT_W'(7);
      default:            lim = CNT_W'(15);
    endcase
    return lim;
  endfunction

  // A beat counts only when granted and the slave is not stalling
  assign beat_acc_c = hgrant & ~hwait;

  // Saturating beat counter increment
  assign cnt_inc_c = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_W'(1);

  // Final-beat decode from registered state
  assign beat_last = (state_q != S_IDLE) && (beat_cnt == limit_q);

`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  // Abort pulse is visible in the last ungranted REQUEST cycle itself
  assign timeout_err = abort_c;
`endif

  // State register and registered outputs
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= S_IDLE;
      limit_q   <= '0;
      beat_cnt  <= '0;
      hreq      <= 1'b0;
      hprior    <= '0;
      hburst    <= HB_SINGLE;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      limit_q   <= limit_nxt;
      beat_cnt  <= beat_cnt_nxt;
      hreq      <= hreq_nxt;
      hprior    <= hprior_nxt;
      hburst    <= hburst_nxt;
      done      <= done_nxt;
      cmd_ready <= cmd_ready_nxt;
    end
  end

`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  // Ungranted-cycle counter for the REQUEST phase
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_nxt;
    end
  end
`endif

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state_q;
    limit_nxt    = limit_q;
    beat_cnt_nxt = beat_cnt;
    hprior_nxt   = hprior;
    hburst_nxt   = hburst;
    done_nxt     = 1'b0;
    abort_c      = 1'b0;
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
    to_cnt_nxt   = to_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt    = S_REQUEST;
          limit_nxt    = burst_limit(cmd_burst, cmd_len);
          beat_cnt_nxt = '0;
          hprior_nxt   = cmd_prior;
          hburst_nxt   = cmd_burst;
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
          to_cnt_nxt   = '0;
`endif
        end
      end

      S_REQUEST: begin
        if (beat_acc_c) begin
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
          to_cnt_nxt = '0;
`endif
          if (limit_q == '0) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            beat_cnt_nxt = cnt_inc_c;
            state_nxt    = S_BURST;
          end
        end else begin
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
          if (to_cnt_q == TO_LAST) begin
            abort_c   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            to_cnt_nxt = to_cnt_q + TO_W'(1);
          end
`endif
        end
      end

      S_BURST: begin
        if (beat_acc_c) begin
          if (beat_cnt == limit_q) begin
            done_nxt     = 1'b1;
            beat_cnt_nxt = '0;
            state_nxt    = S_IDLE;
          end else begin
            beat_cnt_nxt = cnt_inc_c;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Request follows the next state; a new command waits out the done/abort cycle
    hreq_nxt      = (state_nxt != S_IDLE);
    cmd_ready_nxt = (state_nxt == S_IDLE) && !done_nxt && !abort_c;
  end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Self-checking bench for ahb_master_req_ctrl: a driver issues commands and
// grant patterns, pushing the expected transaction onto a scoreboard queue; a
// negedge monitor pops and compares when the DUT completes each transaction.
module tb_ahb_master_req_ctrl;

  localparam int unsigned PB = 1;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic          cmd_valid;
  logic [2:0]    cmd_burst;
  logic [3:0]    cmd_len;
  logic [PB-1:0] cmd_prior;
  logic          cmd_ready;
  logic          hreq;
  logic [PB-1:0] hprior;
  logic [2:0]    hburst;
  logic          hgrant;
  logic          hwait;
  logic [3:0]    beat_cnt;
  logic          beat_last;
  logic          done;
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
  logic          timeout_err;
`endif

  typedef struct {
    logic [2:0] burst;
    logic       prior;
    int         nb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_cur;
  int   checks    = 0;
  int   errors    = 0;
  int   grants    = 0;
  int   done_cnt  = 0;
  int   done_exp  = 0;
  int   low_run   = 2;
  logic prev_done = 1'b0;
  logic prev_hreq = 1'b0;

  ahb_master_req_ctrl #(
    .PRIOR_BIT      (PB),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .cmd_valid   (cmd_valid),
    .cmd_burst   (cmd_burst),
    .cmd_len     (cmd_len),
    .cmd_prior   (cmd_prior),
    .cmd_ready   (cmd_ready),
    .hreq        (hreq),
    .hprior      (hprior),
    .hburst      (hburst),
    .hgrant      (hgrant),
    .hwait       (hwait),
    .beat_cnt    (beat_cnt),
    .beat_last   (beat_last),
    .done        (done)
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 hclk = ~hclk;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference beat count per burst type
  function automatic int exp_beats(input logic [2:0] burst, input logic [3:0] len);
    case (burst)
      3'd0:       return 1;
      3'd1:       return int'(len) + 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  // Monitor: per-cycle checks against the head of the scoreboard
  always @(negedge hclk) begin
    if (!hreset_n) begin
      exp_q.delete();
      grants    = 0;
      prev_done = 1'b0;
      prev_hreq = 1'b0;
      low_run   = 2;
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_hreq", 32'(hreq), 32'd0);
    end else begin
      if (prev_done) check_eq("hreq_after_done", 32'(hreq), 32'd0);
      if (hreq && !prev_hreq) check_eq("hreq_low_gap", 32'(low_run >= 1), 32'd1);
      low_run = hreq ? 0 : low_run + 1;
      if (hreq) begin
        if (exp_q.size() == 0) begin
          check_eq("hreq_spurious", 32'(hreq), 32'd0);
        end else begin
          mon_cur = exp_q[0];
          check_eq("hburst", 32'(hburst), 32'(mon_cur.burst));
          check_eq("hprior", 32'(hprior), 32'(mon_cur.prior));
          check_eq("beat_cnt", 32'(beat_cnt), 32'(grants));
          check_eq("beat_last", 32'(beat_last), 32'(grants == mon_cur.nb - 1));
          if (hgrant && !hwait) grants++;
        end
      end else begin
        check_eq("beat_last_idle", 32'(beat_last), 32'd0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("done_spurious", 32'(done), 32'd0);
        end else begin
          mon_cur = exp_q.pop_front();
          check_eq("done_grants", 32'(grants), 32'(mon_cur.nb));
          check_eq("done_beat_cnt", 32'(beat_cnt), 32'd0);
          check_eq("done_cmd_ready", 32'(cmd_ready), 32'd0);
          grants = 0;
          done_cnt++;
        end
      end
`ifdef AHB_MASTER_REQ_TIMEOUT_EN
      if (timeout_err) begin
        check_eq("to_no_done", 32'(done), 32'd0);
        check_eq("to_grants", 32'(grants), 32'd0);
        if (exp_q.size() != 0) mon_cur = exp_q.pop_front();
        grants = 0;
      end
`endif
      prev_done = done;
      prev_hreq = hreq;
    end
  end

  // Present a command and wait (bounded) for it to be accepted
  task automatic issue_cmd(input logic [2:0] burst, input logic [3:0] len, input logic prior);
    logic rdy;
    int   n;
    exp_q.push_back('{burst: burst, prior: prior, nb: exp_beats(burst, len)});
    cmd_valid = 1'b1;
    cmd_burst = burst;
    cmd_len   = len;
    cmd_prior = PB'(prior);
    n = 0;
    do begin
      @(negedge hclk);
      rdy = cmd_ready;
      @(posedge hclk);
      #1;
      n++;
    end while (!rdy && n < 20);
    check_eq("cmd_accepted", 32'(rdy), 32'd1);
    cmd_valid = 1'b0;
    cmd_burst = 3'($urandom_range(0, 7));
    cmd_len   = 4'($urandom_range(0, 15));
    check_eq("hreq_rise", 32'(hreq), 32'd1);
  endtask

  // One transaction: grant delay, optional stall, optional reset at a beat index
  task automatic run_txn(input logic [2:0] burst, input logic [3:0] len, input logic prior,
                         input int gdelay, input int stall_after, input int stall_len,
                         input int reset_at);
    int nb, g, stalled, guard;
    nb = exp_beats(burst, len);
    issue_cmd(burst, len, prior);
    hgrant = 1'b0;
    hwait  = 1'b0;
    for (int i = 0; i < gdelay; i++) begin
      @(posedge hclk);
      #1;
    end
    g = 0;
    stalled = 0;
    guard = 0;
    while (g < nb && guard < 200) begin
      if (reset_at >= 0 && g == reset_at) begin
        hgrant   = 1'b0;
        hreset_n = 1'b0;
        #1;
        check_eq("arst_hreq", 32'(hreq), 32'd0);
        check_eq("arst_hprior", 32'(hprior), 32'd0);
        check_eq("arst_hburst", 32'(hburst), 32'd0);
        check_eq("arst_beat_cnt", 32'(beat_cnt), 32'd0);
        check_eq("arst_beat_last", 32'(beat_last), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        @(posedge hclk);
        #1;
        check_eq("post_rst_hreq", 32'(hreq), 32'd0);
        check_eq("post_rst_done", 32'(done), 32'd0);
        return;
      end
      if (g == stall_after && stalled < stall_len) begin
        hgrant = 1'b0;
        hwait  = 1'b1;
        stalled++;
      end else begin
        hgrant = 1'b1;
        hwait  = 1'b0;
      end
      @(posedge hclk);
      #1;
      if (hgrant && !hwait) g++;
      guard++;
    end
    hgrant = 1'b0;
    hwait  = 1'b0;
    check_eq("done_pulse", 32'(done), 32'd1);
    done_exp++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    hreset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_burst = 3'd0;
    cmd_len   = 4'd0;
    cmd_prior = '0;
    hgrant    = 1'b0;
    hwait     = 1'b0;
    repeat (2) @(negedge hclk);
    check_eq("reset_hreq", 32'(hreq), 32'd0);
    check_eq("reset_hprior", 32'(hprior), 32'd0);
    check_eq("reset_hburst", 32'(hburst), 32'd0);
    check_eq("reset_beat_cnt", 32'(beat_cnt), 32'd0);
    check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("reset_beat_last", 32'(beat_last), 32'd0);
    @(posedge hclk);
    #1;
    hreset_n = 1'b1;
    @(posedge hclk);
    #1;

    // SINGLE, prior 1, grant one cycle after hreq rises
    run_txn(3'd0, 4'd0, 1'b1, 1, -1, 0, -1);
    // INCR4, continuous grant
    run_txn(3'd3, 4'd9, 1'b0, 0, -1, 0, -1);
    // INCR8 with a 3-cycle stall after beat 2
    run_txn(3'd5, 4'd0, 1'b1, 0, 3, 3, -1);
    // INCR len 5, then an immediate second command
    run_txn(3'd1, 4'd5, 1'b0, 0, -1, 0, -1);
    run_txn(3'd2, 4'd0, 1'b1, 0, -1, 0, -1);
    // WRAP16 reset at beat 9
    run_txn(3'd6, 4'd0, 1'b1, 0, -1, 0, 9);
    // Boundary lengths and remaining burst types
    run_txn(3'd1, 4'd0, 1'b0, 2, -1, 0, -1);
    run_txn(3'd1, 4'd15, 1'b1, 0, 15, 2, -1);
    run_txn(3'd4, 4'd2, 1'b0, 1, 7, 1, -1);
    run_txn(3'd7, 4'd0, 1'b1, 0, 0, 2, -1);
    for (int i = 0; i < 6; i++) begin
      run_txn(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 16)),
              int'($urandom_range(0, 2)), -1);
    end

`ifdef AHB_MASTER_REQ_TIMEOUT_EN
    // Never granted: abort in the 64th REQUEST cycle
    begin
      int cyc;
      repeat (2) @(posedge hclk);
      #1;
      issue_cmd(3'd3, 4'd0, 1'b1);
      hgrant = 1'b0;
      cyc = 1;
      while (!timeout_err && cyc < 200) begin
        @(posedge hclk);
        #1;
        cyc++;
      end
      check_eq("timeout_cycle", 32'(cyc), 32'd64);
      @(posedge hclk);
      #1;
      check_eq("timeout_hreq_low", 32'(hreq), 32'd0);
      check_eq("timeout_pulse_end", 32'(timeout_err), 32'd0);
      check_eq("timeout_no_done", 32'(done), 32'd0);
    end
`endif

    repeat (4) @(posedge hclk);
    #1;
    check_eq("done_count", 32'(done_cnt), 32'(done_exp));
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
